// File: rtl/branch_resolve_unit.sv
// Branch resolution unit: evaluates a RISC-V branch condition from the flags of
// A-B, presents the result on a valid/ready handshake and requests a pipeline
// flush of FLUSH_CYCLES cycles after a taken branch. Keeps saturating
// statistics of resolved and taken branches.
module branch_resolve_unit #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       cond,
  input  logic             zero_flag,
  input  logic             negative_flag,
  input  logic             overflow_flag,
  input  logic             carry_flag,
  input  logic [WIDTH-1:0] target,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             taken,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             illegal,
  output logic [3:0]       status,
  output logic             flush,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic [1:0] {IDLE, HOLD, FLUSH} state_e;

  localparam logic [3:0]       FLUSH_INIT = 4'(FLUSH_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

  state_e             state_q;
  logic               taken_q, illegal_q, flush_q;
  logic [WIDTH-1:0]   redirect_q;
  logic [3:0]         status_q;
  logic [3:0]         fcnt_q;
  logic [CNT_W-1:0]   bcnt_q, tcnt_q;
  logic               taken_d, illegal_d;
  logic               accept, retire_taken;

  assign accept       = in_valid && (state_q == IDLE);
  assign retire_taken = (state_q == HOLD) && out_ready && taken_q;

  // Condition decode on the live flags, so the result is ready at acceptance.
  always_comb begin
    taken_d   = 1'b0;
    illegal_d = 1'b0;
    case (cond)
      3'b000:  taken_d = zero_flag;
      3'b001:  taken_d = ~zero_flag;
      3'b100:  taken_d = negative_flag ^ overflow_flag;
      3'b101:  taken_d = ~(negative_flag ^ overflow_flag);
      3'b110:  taken_d = ~carry_flag;
      3'b111:  taken_d = carry_flag;
      default: illegal_d = 1'b1;
    endcase
  end

  // Control FSM with the latched result; the result only changes on accept,
  // so it stays stable through back-pressure and after retirement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
      status_q   <= '0;
      fcnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          state_q    <= HOLD;
          taken_q    <= taken_d;
          illegal_q  <= illegal_d;
          redirect_q <= taken_d ? target : '0;
          status_q   <= {negative_flag, zero_flag, carry_flag, overflow_flag};
        end
        HOLD: if (out_ready) begin
          if (taken_q) begin
            state_q <= FLUSH;
            flush_q <= 1'b1;
            fcnt_q  <= FLUSH_INIT;
          end else begin
            state_q <= IDLE;
          end
        end
        FLUSH: begin
          // Counter holds the flush cycles still to go including this one.
          if (fcnt_q <= 4'd1) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            fcnt_q  <= '0;
          end else begin
            fcnt_q <= fcnt_q - 4'd1;
          end
        end
        default: begin
          state_q <= IDLE;
          flush_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      if (accept && bcnt_q != CNT_MAX)       bcnt_q <= bcnt_q + 1'b1;
      if (retire_taken && tcnt_q != CNT_MAX) tcnt_q <= tcnt_q + 1'b1;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == HOLD);
  assign taken        = taken_q;
  assign illegal      = illegal_q;
  assign redirect_pc  = redirect_q;
  assign status       = status_q;
  assign flush        = flush_q;
  assign branch_count = bcnt_q;
  assign taken_count  = tcnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit (built with CNT_W=4 so saturation is
// reachable). Inputs change and outputs are sampled 1 time unit after posedge.
module tb_branch_resolve_unit;
  localparam int W = 32;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [2:0] cond = '0;
  logic zf = 0, nf = 0, vf = 0, cf = 0;
  logic [W-1:0] target = '0;
  logic in_ready, out_valid, taken, illegal, flush;
  logic [W-1:0] redirect_pc;
  logic [3:0] status;
  logic [CW-1:0] branch_count, taken_count;

  int tests = 0, fails = 0;

  branch_resolve_unit #(.WIDTH(W), .FLUSH_CYCLES(2), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cond(cond), .zero_flag(zf), .negative_flag(nf), .overflow_flag(vf),
    .carry_flag(cf), .target(target), .out_valid(out_valid),
    .out_ready(out_ready), .taken(taken), .redirect_pc(redirect_pc),
    .illegal(illegal), .status(status), .flush(flush),
    .branch_count(branch_count), .taken_count(taken_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = 0; out_ready = 0; rst_n = 0;
    step();
    rst_n = 1;
  endtask

  // Present one branch; flags given as {N,Z,C,V}.
  task automatic drive(input logic [2:0] c, input logic [3:0] f, input logic [W-1:0] t);
    in_valid = 1; cond = c; {nf, zf, cf, vf} = f; target = t;
  endtask

  // Wait for IDLE after a handshake, counting flush cycles seen.
  task automatic wait_idle(output int fl, output bit ok);
    fl = 0; ok = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (flush) fl++;
      if (in_ready) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    in_valid = 0; out_ready = 0; rst_n = 0;
    #3;
    tests++;
    if ({in_ready, out_valid, taken, illegal, flush} !== 5'b10000 ||
        redirect_pc !== '0 || status !== 4'h0 || branch_count !== '0 || taken_count !== '0) begin
      fails++;
      $display("FAIL reset: rdy/ov/tk/il/fl=%b pc=%h st=%h bc=%0d tc=%0d, want 10000/0/0/0/0",
               {in_ready, out_valid, taken, illegal, flush}, redirect_pc, status, branch_count, taken_count);
    end
    step();
    rst_n = 1;
  endtask

  task automatic test_taken_flush();
    int fl;
    do_reset();
    drive(3'b000, 4'b0100, 32'h100); out_ready = 1;
    step(); in_valid = 0;
    tests++;
    if ({in_ready, out_valid, taken, illegal, flush} !== 5'b01100 || redirect_pc !== 32'h100) begin
      fails++;
      $display("FAIL beq_taken: rdy/ov/tk/il/fl=%b pc=%h, want 01100 pc=100",
               {in_ready, out_valid, taken, illegal, flush}, redirect_pc);
    end
    fl = 0;
    for (int k = 0; k < 2; k++) begin
      step();
      if (flush && !out_valid && !in_ready) fl++;
    end
    tests++;
    if (fl !== 2) begin fails++; $display("FAIL beq_flush_len: got %0d flush cycles, want 2", fl); end
    step();
    tests++;
    if ({in_ready, flush, taken} !== 3'b101 || redirect_pc !== 32'h100 ||
        branch_count !== 4'd1 || taken_count !== 4'd1) begin
      fails++;
      $display("FAIL beq_after: rdy/fl/tk=%b pc=%h bc=%0d tc=%0d, want 101 pc=100 bc=1 tc=1",
               {in_ready, flush, taken}, redirect_pc, branch_count, taken_count);
    end
  endtask

  task automatic test_not_taken();
    do_reset();
    drive(3'b100, 4'b1001, 32'h200); out_ready = 1;
    step(); in_valid = 0;
    tests++;
    if ({out_valid, taken, illegal} !== 3'b100 || redirect_pc !== '0 || status !== 4'b1001) begin
      fails++;
      $display("FAIL blt_nt: ov/tk/il=%b pc=%h st=%b, want 100 pc=0 st=1001",
               {out_valid, taken, illegal}, redirect_pc, status);
    end
    step();
    tests++;
    if ({in_ready, out_valid, flush} !== 3'b100 || taken_count !== 4'd0 || branch_count !== 4'd1) begin
      fails++;
      $display("FAIL blt_nt_idle: rdy/ov/fl=%b tc=%0d bc=%0d, want 100 tc=0 bc=1",
               {in_ready, out_valid, flush}, taken_count, branch_count);
    end
  endtask

  task automatic test_conditions();
    logic [2:0] vc [10] = '{3'b000, 3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b111, 3'b010, 3'b011};
    logic [3:0] vf4[10] = '{4'b0100, 4'b0000, 4'b0100, 4'b1000, 4'b1001, 4'b0010, 4'b0010, 4'b0000, 4'b0100, 4'b0100};
    logic       vt [10] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    logic       vi [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int fl; bit ok;
    logic [W-1:0] t;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      t = 32'h1000 + 32'(i * 4);
      drive(vc[i], vf4[i], t);
      step(); in_valid = 0;
      tests++;
      if ({out_valid, taken, illegal} !== {1'b1, vt[i], vi[i]} ||
          redirect_pc !== (vt[i] ? t : '0) || status !== vf4[i]) begin
        fails++;
        $display("FAIL cond[%0d] %b: ov/tk/il=%b pc=%h st=%b, want %b pc=%h st=%b", i, vc[i],
                 {out_valid, taken, illegal}, redirect_pc, status, {1'b1, vt[i], vi[i]},
                 vt[i] ? t : '0, vf4[i]);
      end
      wait_idle(fl, ok);
      tests++;
      if (!ok || fl !== (vt[i] ? 2 : 0)) begin
        fails++;
        $display("FAIL cond_flush[%0d]: idle=%0d flush_cycles=%0d, want 1 and %0d", i, ok, fl, vt[i] ? 2 : 0);
      end
    end
  endtask

  task automatic test_backpressure();
    int fl; bit ok;
    do_reset();
    drive(3'b110, 4'b1001, 32'hABCD_0000); out_ready = 0;
    step();
    for (int i = 0; i < 5; i++) begin
      // Competing inputs while holding must be ignored.
      in_valid = i[0];
      cond = 3'b000; {nf, zf, cf, vf} = 4'b0110; target = 32'hDEAD_0000 + 32'(i);
      tests++;
      if ({out_valid, taken, in_ready} !== 3'b110 || redirect_pc !== 32'hABCD_0000 || status !== 4'b1001) begin
        fails++;
        $display("FAIL hold[%0d]: ov/tk/rdy=%b pc=%h st=%b, want 110 pc=abcd0000 st=1001",
                 i, {out_valid, taken, in_ready}, redirect_pc, status);
      end
      step();
    end
    in_valid = 0; out_ready = 1;
    step();
    tests++;
    if ({out_valid, flush} !== 2'b01) begin
      fails++; $display("FAIL hold_release: ov/fl=%b, want 01", {out_valid, flush});
    end
    wait_idle(fl, ok);
    tests++;
    if (!ok || branch_count !== 4'd1 || taken_count !== 4'd1) begin
      fails++;
      $display("FAIL hold_counts: idle=%0d bc=%0d tc=%0d, want 1 1 1", ok, branch_count, taken_count);
    end
  endtask

  task automatic test_illegal();
    int fl; bit ok;
    do_reset();
    drive(3'b011, 4'b0110, 32'h300); out_ready = 1;
    step(); in_valid = 0;
    tests++;
    if ({out_valid, taken, illegal} !== 3'b101 || redirect_pc !== '0) begin
      fails++;
      $display("FAIL illegal: ov/tk/il=%b pc=%h, want 101 pc=0", {out_valid, taken, illegal}, redirect_pc);
    end
    wait_idle(fl, ok);
    tests++;
    if (!ok || fl !== 0 || branch_count !== 4'd1 || taken_count !== 4'd0 || illegal !== 1'b1) begin
      fails++;
      $display("FAIL illegal_after: idle=%0d fl=%0d bc=%0d tc=%0d il=%b, want 1 0 1 0 1",
               ok, fl, branch_count, taken_count, illegal);
    end
  endtask

  task automatic test_saturation();
    int fl; bit ok;
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      drive(3'b111, 4'b0010, 32'h40);
      step(); in_valid = 0;
      wait_idle(fl, ok);
      if (i == 13) begin
        tests++;
        if (branch_count !== 4'd14 || taken_count !== 4'd14) begin
          fails++; $display("FAIL count14: bc=%0d tc=%0d, want 14 14", branch_count, taken_count);
        end
      end
    end
    tests++;
    if (!ok || branch_count !== 4'd15 || taken_count !== 4'd15) begin
      fails++; $display("FAIL saturate: idle=%0d bc=%0d tc=%0d, want 1 15 15", ok, branch_count, taken_count);
    end
  endtask

  task automatic test_reset_in_flush();
    do_reset();
    drive(3'b001, 4'b1000, 32'h500); out_ready = 1;
    step(); in_valid = 0;
    step();
    step();
    tests++;
    if (flush !== 1'b1) begin fails++; $display("FAIL rst_pre: flush=%b, want 1", flush); end
    rst_n = 0;
    #1;
    tests++;
    if ({in_ready, out_valid, taken, illegal, flush} !== 5'b10000 || redirect_pc !== '0 ||
        status !== 4'h0 || branch_count !== '0 || taken_count !== '0) begin
      fails++;
      $display("FAIL rst_flush: rdy/ov/tk/il/fl=%b pc=%h st=%h bc=%0d tc=%0d, want 10000/0/0/0/0",
               {in_ready, out_valid, taken, illegal, flush}, redirect_pc, status, branch_count, taken_count);
    end
    #3 rst_n = 1;
    step();
    tests++;
    if ({in_ready, flush} !== 2'b10) begin
      fails++; $display("FAIL rst_release: rdy/fl=%b, want 10", {in_ready, flush});
    end
  endtask

  initial begin
    test_reset();
    test_taken_flush();
    test_not_taken();
    test_conditions();
    test_backpressure();
    test_illegal();
    test_saturation();
    test_reset_in_flush();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
